// File: rtl/loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
// Shared types and constants for the boot-time program loader.
//   ld_state_e    : loader FSM states
//   LD_LEN_W      : width of the image length header (words)
//   LD_WORD_BYTES : bytes per instruction word
// -----------------------------------------------------------------------------
package loader_pkg;

    localparam int LD_LEN_W      = 16;
    localparam int LD_WORD_BYTES = 4;

    typedef enum logic [2:0] {
        LD_LEN_LO,
        LD_LEN_HI,
        LD_DATA,
        LD_CHK,
        LD_DONE,
        LD_ERR
    } ld_state_e;

endpackage

// File: rtl/loader_word_asm.sv
// -----------------------------------------------------------------------------
// loader_word_asm
// Assembles little-endian instruction words from a byte stream.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   clear_i        : synchronous clear (loader restart)
//   byte_i         : payload byte
//   byte_en_i      : byte_i is accepted this cycle
//   last_byte_o    : combinational, the accepted byte completes a word
//   word_o         : registered completed word
//   word_valid_o   : registered one-cycle strobe, word_o is new
// -----------------------------------------------------------------------------
module loader_word_asm
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic [7:0]  byte_i,
    input  logic        byte_en_i,
    output logic        last_byte_o,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    localparam int CNT_W = $clog2(LD_WORD_BYTES);
    localparam int SH_W  = 8 * (LD_WORD_BYTES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [SH_W-1:0]  sh_q;
    logic [31:0]      word_q;
    logic             valid_q;

    assign last_byte_o  = byte_en_i && (cnt_q == CNT_W'(LD_WORD_BYTES - 1));
    assign word_o       = word_q;
    assign word_valid_o = valid_q;

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            cnt_q   <= '0;
            sh_q    <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (byte_en_i) begin
                // counter wraps naturally from the last byte back to 0
                cnt_q <= cnt_q + CNT_W'(1);
                if (last_byte_o) begin
                    word_q  <= {byte_i, sh_q};
                    valid_q <= 1'b1;
                end else begin
                    // first byte ends up in the LSBs
                    sh_q <= {byte_i, sh_q[SH_W-1:8]};
                end
            end
        end
    end

endmodule

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
// Boot-time loader: receives a byte stream (LEN_LO, LEN_HI, 4*N payload bytes,
// optional XOR checksum), writes words into instruction memory from address 0
// and holds the core in reset until a complete image is written.
// Optional feature macro: LOADER_CHECKSUM_EN (adds CHK state + XOR check).
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   start                 : restart pulse, honoured in DONE/ERR only
//   in_data/in_valid      : byte stream input
//   in_ready              : loader can accept a byte
//   imem_we/addr/wdata    : registered instruction-memory write port
//   core_reset            : keeps the pipeline in reset
//   done / error          : image loaded / image rejected
//   word_count            : words written so far
//
// state     | meaning
// ----------+---------------------------------------------
// LD_LEN_LO | waiting for low byte of word count
// LD_LEN_HI | waiting for high byte, range check
// LD_DATA   | receiving payload words
// LD_CHK    | waiting for checksum byte (checksum build)
// LD_DONE   | image loaded, core released
// LD_ERR    | image rejected, core held in reset
// -----------------------------------------------------------------------------
module prog_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [7:0]          in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                imem_we,
    output logic [ADDR_W-1:0]   imem_addr,
    output logic [31:0]         imem_wdata,
    output logic                core_reset,
    output logic                done,
    output logic                error,
    output logic [LD_LEN_W-1:0] word_count
);

    localparam int unsigned LEN_CAP = 2 ** ADDR_W;

`ifdef LOADER_CHECKSUM_EN
    localparam ld_state_e POST_DATA = LD_CHK;
    logic [7:0] xor_q, xor_d;
`else
    localparam ld_state_e POST_DATA = LD_DONE;
`endif

    ld_state_e           state_q, state_d;
    logic [LD_LEN_W-1:0] len_q, len_d;
    logic [LD_LEN_W-1:0] word_count_q, word_count_d;
    logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
    logic [LD_LEN_W-1:0] len_full;
    logic                accept, restart, data_en, last_byte, word_valid;
    logic [31:0]         word;

    assign accept   = in_valid && in_ready;
    assign restart  = start && (state_q == LD_DONE || state_q == LD_ERR);
    assign data_en  = accept && (state_q == LD_DATA);
    assign len_full = {in_data, len_q[7:0]};

    loader_word_asm u_word_asm (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (restart),
        .byte_i      (in_data),
        .byte_en_i   (data_en),
        .last_byte_o (last_byte),
        .word_o      (word),
        .word_valid_o(word_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= LD_LEN_LO;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LD_LEN_LO: if (accept) state_d = LD_LEN_HI;
            LD_LEN_HI: begin
                if (accept) begin
                    if (32'(len_full) > LEN_CAP)  state_d = LD_ERR;
                    else if (len_full == '0)      state_d = POST_DATA;
                    else                          state_d = LD_DATA;
                end
            end
            LD_DATA: begin
                if (last_byte && (word_count_q + LD_LEN_W'(1) == len_q))
                    state_d = POST_DATA;
            end
`ifdef LOADER_CHECKSUM_EN
            LD_CHK: begin
                if (accept) state_d = (in_data == xor_q) ? LD_DONE : LD_ERR;
            end
`endif
            LD_DONE, LD_ERR: if (start) state_d = LD_LEN_LO;
            default: state_d = LD_LEN_LO;
        endcase
    end

    always_comb begin
        in_ready   = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        core_reset = 1'b1;
        case (state_q)
            LD_LEN_LO, LD_LEN_HI, LD_DATA, LD_CHK: in_ready = 1'b1;
            LD_DONE: begin
                done       = 1'b1;
                // restart must put the core back in reset immediately
                core_reset = start;
            end
            LD_ERR:  error = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        len_d        = len_q;
        word_count_d = word_count_q;
        imem_addr_d  = imem_addr_q;
`ifdef LOADER_CHECKSUM_EN
        xor_d        = xor_q;
        if (data_en) xor_d = xor_q ^ in_data;
        if (restart) xor_d = '0;
`endif
        if (accept && state_q == LD_LEN_LO) len_d[7:0]  = in_data;
        if (accept && state_q == LD_LEN_HI) len_d[15:8] = in_data;
        if (last_byte) begin
            imem_addr_d  = word_count_q[ADDR_W-1:0];
            word_count_d = word_count_q + LD_LEN_W'(1);
        end
        if (restart) word_count_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len_q        <= '0;
            word_count_q <= '0;
            imem_addr_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
            xor_q        <= '0;
`endif
        end else begin
            len_q        <= len_d;
            word_count_q <= word_count_d;
            imem_addr_q  <= imem_addr_d;
`ifdef LOADER_CHECKSUM_EN
            xor_q        <= xor_d;
`endif
        end
    end

    assign imem_we    = word_valid;
    assign imem_wdata = word;
    assign imem_addr  = imem_addr_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader
// Self-checking bench for prog_loader. Expected memory writes are queued as
// stimulus is driven and popped by a monitor on every imem_we.
// Honours LOADER_CHECKSUM_EN to match the DUT build.
// -----------------------------------------------------------------------------
module tb_prog_loader;

    localparam int ADDR_W = 10;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic              clk;
    logic              reset;
    logic              start;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_reset;
    logic              done;
    logic              error;
    logic [15:0]       word_count;

    prog_loader #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .core_reset(core_reset),
        .done      (done),
        .error     (error),
        .word_count(word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    typedef struct {
        int          n;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        logic [7:0]  delta;
        bit          gap;
        bit          exp_done;
        bit          exp_err;
        int          exp_wc;
    } vec_t;

    int          n_checks;
    int          n_errors;
    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [31:0] img [0:1023];
    vec_t        vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL stray_write: got addr %0h data %08h, required no write (t=%0t)",
                         imem_addr, imem_wdata, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(imem_addr), 32'(mon_e.addr));
                check("wr_data", imem_wdata, mon_e.data);
            end
        end
    end

    // called and returns at a negedge
    task automatic send_byte(input logic [7:0] b, input bit word_end);
        int waited;
        waited   = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1) begin
            @(negedge clk);
            waited++;
            if (waited > 20) begin
                n_checks++;
                n_errors++;
                $display("FAIL ready_timeout: got in_ready=%b for %0d cycles, required 1", in_ready, waited);
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("we_timing", 32'(imem_we), 32'(word_end));
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_stream(input int n, input logic [7:0] delta, input bit gap);
        logic [7:0]  x;
        logic [7:0]  b;
        logic [15:0] len;
        wr_t         e;
        x   = 8'h00;
        len = 16'(n);
        send_byte(len[7:0], 1'b0);
        send_byte(len[15:8], 1'b0);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 4; k++) begin
                b = img[i][8*k +: 8];
                x = x ^ b;
                if (k == 3) begin
                    e.addr = i[ADDR_W-1:0];
                    e.data = img[i];
                    exp_q.push_back(e);
                end
                if (gap) idle();
                send_byte(b, k == 3);
            end
        end
        if (CHK_EN) send_byte(x ^ delta, 1'b0);
    endtask

    task automatic restart();
        start = 1'b1;
        #1;
        check("rst_core_reset_same_cycle", 32'(core_reset), 32'd1);
        check("rst_ready_blocked", 32'(in_ready), 32'd0);
        @(negedge clk);
        start = 1'b0;
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_word_count", 32'(word_count), 32'd0);
        check("rst_core_reset", 32'(core_reset), 32'd1);
    endtask

    task automatic check_reset_vals();
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_imem_we", 32'(imem_we), 32'd0);
        check("reset_imem_addr", 32'(imem_addr), 32'd0);
        check("reset_imem_wdata", imem_wdata, 32'd0);
        check("reset_core_reset", 32'(core_reset), 32'd1);
        check("reset_done", 32'(done), 32'd0);
        check("reset_error", 32'(error), 32'd0);
        check("reset_word_count", 32'(word_count), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, required finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;

        //            n  w0            w1            w2            delta  gap   done     err     wc
        vecs[0] = '{2, 32'h00000013, 32'h00100093, 32'h00000000, 8'h00, 1'b0, 1'b1,    1'b0,   2};
        vecs[1] = '{2, 32'h00000013, 32'h00100093, 32'h00000000, 8'h01, 1'b0, !CHK_EN, CHK_EN, 2};
        vecs[2] = '{3, 32'hDEADBEEF, 32'h01234567, 32'hA5A5005A, 8'h00, 1'b1, 1'b1,    1'b0,   3};
        vecs[3] = '{0, 32'h00000000, 32'h00000000, 32'h00000000, 8'h00, 1'b0, 1'b1,    1'b0,   0};
        vecs[4] = '{1, 32'hCAFEF00D, 32'h00000000, 32'h00000000, 8'h00, 1'b1, 1'b1,    1'b0,   1};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_reset_vals();

        for (int i = 0; i < 5; i++) begin
            if (i > 0) restart();
            img[0] = vecs[i].w0;
            img[1] = vecs[i].w1;
            img[2] = vecs[i].w2;
            send_stream(vecs[i].n, vecs[i].delta, vecs[i].gap);
            check("vec_done", 32'(done), 32'(vecs[i].exp_done));
            check("vec_error", 32'(error), 32'(vecs[i].exp_err));
            check("vec_core_reset", 32'(core_reset), 32'(!vecs[i].exp_done));
            check("vec_in_ready", 32'(in_ready), 32'd0);
            check("vec_word_count", 32'(word_count), 32'(vecs[i].exp_wc));
        end

        // oversized length 0xFFFF: error right after LEN_HI, no write
        restart();
        send_byte(8'hFF, 1'b0);
        send_byte(8'hFF, 1'b0);
        check("big_error", 32'(error), 32'd1);
        check("big_done", 32'(done), 32'd0);
        check("big_core_reset", 32'(core_reset), 32'd1);
        check("big_in_ready", 32'(in_ready), 32'd0);
        repeat (3) idle();

        // one over capacity
        restart();
        send_byte(8'h01, 1'b0);
        send_byte(8'h04, 1'b0);
        check("cap_plus1_error", 32'(error), 32'd1);
        repeat (2) idle();

        // exactly capacity: accepted, fills every address
        restart();
        for (int i = 0; i < 1024; i++) img[i] = (32'(i) * 32'h00010003) ^ 32'h5A0000C3;
        send_stream(1024, 8'h00, 1'b0);
        check("cap_done", 32'(done), 32'd1);
        check("cap_error", 32'(error), 32'd0);
        check("cap_word_count", 32'(word_count), 32'd1024);

        // reset in the middle of word 1, then a fresh single-word image
        restart();
        img[0] = 32'h11223344;
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        mon_e.addr = '0;
        mon_e.data = img[0];
        exp_q.push_back(mon_e);
        send_byte(8'h44, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h11, 1'b1);
        send_byte(8'h88, 1'b0);
        send_byte(8'h77, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_vals();
        repeat (4) idle();
        img[0] = 32'h0BADF00D;
        send_stream(1, 8'h00, 1'b0);
        check("post_reset_done", 32'(done), 32'd1);
        check("post_reset_word_count", 32'(word_count), 32'd1);
        check("post_reset_core_reset", 32'(core_reset), 32'd0);

        repeat (4) idle();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
